// File: rtl/mem_access_unit_if.sv
// Data-bus interface between the MEM-stage access unit (master) and a
// memory responder (slave). The request side is driven by the unit; the
// responder returns ack and read data.
interface mem_access_unit_if #(
    parameter int DATA_W = 32
);
    logic              req;
    logic              we;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ack;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, we, addr, wdata,
        input  ack, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output ack, rdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage access unit: converts the EX/MEM memory command into a req/ack
// bus transaction, holds the front pipeline while it is outstanding, and
// carries the MEM/WB register.
// Optional feature macro: MEM_TIMEOUT_EN adds an ack timeout that aborts the
// access after TIMEOUT_CYCLES busy cycles and pulses bus_err.
module mem_access_unit #(
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_regwr,
    input  logic              mem_memtoreg,
    input  logic              mem_memwr,
    input  logic              mem_dmen,
    input  logic [DATA_W-1:0] mem_result,
    input  logic [DATA_W-1:0] mem_rt,
    input  logic [4:0]        mem_regdst_addr,
    output logic              mem_stall,
    mem_access_unit_if.master dbus,
    output logic              bus_err,
    output logic              wb_regwr,
    output logic              wb_memtoreg,
    output logic [DATA_W-1:0] wb_result,
    output logic [DATA_W-1:0] wb_rdata,
    output logic [4:0]        wb_regdst_addr
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state_reg, state_next;
    logic              req_reg, req_next;
    logic              we_reg;
    logic [DATA_W-1:0] addr_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic [DATA_W-1:0] rdata_reg, rdata_next;
    logic              bus_err_reg, bus_err_next;
    logic              latch_cmd;
    logic              timeout_hit;

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = 16;
    logic [CNT_W-1:0] cnt_reg;

    // Count busy cycles without ack; cleared whenever not BUSY so each access starts at 0.
    always_ff @(posedge clk) begin
        if (reset || state_reg != BUSY)
            cnt_reg <= '0;
        else if (!dbus.ack)
            cnt_reg <= cnt_reg + 1'b1;
    end

    // An ack on the terminal cycle takes priority, so only ackless cycles can time out.
    assign timeout_hit = (state_reg == BUSY) && !dbus.ack &&
                         (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign timeout_hit    = 1'b0;
`endif

    // Next-state, request and stall decode; stall is combinational so EX/MEM holds in the same cycle.
    always_comb begin
        state_next   = state_reg;
        req_next     = req_reg;
        rdata_next   = rdata_reg;
        bus_err_next = 1'b0;
        latch_cmd    = 1'b0;
        mem_stall    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (mem_dmen) begin
                    mem_stall  = 1'b1;
                    latch_cmd  = 1'b1;
                    req_next   = 1'b1;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                mem_stall = 1'b1;
                if (dbus.ack) begin
                    rdata_next = dbus.rdata;
                    req_next   = 1'b0;
                    state_next = DONE;
                end else if (timeout_hit) begin
                    rdata_next   = '0;
                    req_next     = 1'b0;
                    bus_err_next = 1'b1;
                    state_next   = DONE;
                end
            end
            DONE: begin
                // mem_dmen still describes the finished op here, so it is not looked at.
                state_next = IDLE;
            end
            default: begin
                req_next   = 1'b0;
                state_next = IDLE;
            end
        endcase
    end

    // FSM, request, captured load data and error pulse registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            req_reg     <= 1'b0;
            rdata_reg   <= '0;
            bus_err_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            req_reg     <= req_next;
            rdata_reg   <= rdata_next;
            bus_err_reg <= bus_err_next;
        end
    end

    // Capture the command once on the IDLE->BUSY edge so it stays stable while waiting.
    always_ff @(posedge clk) begin
        if (reset) begin
            we_reg    <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
        end else if (latch_cmd) begin
            we_reg    <= mem_memwr;
            addr_reg  <= mem_result;
            wdata_reg <= mem_rt;
        end
    end

    // MEM/WB register: bubble while stalled, advance otherwise; a timed-out op writes nothing.
    always_ff @(posedge clk) begin
        if (reset) begin
            wb_regwr       <= 1'b0;
            wb_memtoreg    <= 1'b0;
            wb_result      <= '0;
            wb_rdata       <= '0;
            wb_regdst_addr <= '0;
        end else if (mem_stall) begin
            wb_regwr <= 1'b0;
        end else begin
            wb_regwr       <= mem_regwr & ~bus_err_reg;
            wb_memtoreg    <= mem_memtoreg;
            wb_result      <= mem_result;
            wb_rdata       <= rdata_reg;
            wb_regdst_addr <= mem_regdst_addr;
        end
    end

    assign dbus.req   = req_reg;
    assign dbus.we    = (state_reg == BUSY) ? we_reg    : 1'b0;
    assign dbus.addr  = (state_reg == BUSY) ? addr_reg  : '0;
    assign dbus.wdata = (state_reg == BUSY) ? wdata_reg : '0;
    assign bus_err    = bus_err_reg;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed testbench for mem_access_unit: ALU pass-through, load, store with
// wait states, back-to-back loads, reset mid-access and (with MEM_TIMEOUT_EN)
// the ack timeout.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_regwr, mem_memtoreg, mem_memwr, mem_dmen;
    logic [31:0] mem_result, mem_rt;
    logic [4:0]  mem_regdst_addr;
    logic        mem_stall, bus_err;
    logic        wb_regwr, wb_memtoreg;
    logic [31:0] wb_result, wb_rdata;
    logic [4:0]  wb_regdst_addr;

    int checks   = 0;
    int failures = 0;
    int stall_cnt = 0;
    int req_bursts = 0;
    logic req_prev = 1'b0;
    int s0, b0;

    mem_access_unit_if #(.DATA_W(32)) dbus ();

    mem_access_unit #(.DATA_W(32), .TIMEOUT_CYCLES(8)) dut (
        .clk             (clk),
        .reset           (reset),
        .mem_regwr       (mem_regwr),
        .mem_memtoreg    (mem_memtoreg),
        .mem_memwr       (mem_memwr),
        .mem_dmen        (mem_dmen),
        .mem_result      (mem_result),
        .mem_rt          (mem_rt),
        .mem_regdst_addr (mem_regdst_addr),
        .mem_stall       (mem_stall),
        .dbus            (dbus),
        .bus_err         (bus_err),
        .wb_regwr        (wb_regwr),
        .wb_memtoreg     (wb_memtoreg),
        .wb_result       (wb_result),
        .wb_rdata        (wb_rdata),
        .wb_regdst_addr  (wb_regdst_addr)
    );

    always #5 clk = ~clk;

    // Count stall cycles and request bursts, sampled mid-cycle.
    always @(negedge clk) begin
        if (!reset) begin
            if (mem_stall) stall_cnt <= stall_cnt + 1;
            if (dbus.req && !req_prev) req_bursts <= req_bursts + 1;
        end
        req_prev <= dbus.req;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input logic regwr, input logic memtoreg, input logic memwr,
                          input logic dmen, input logic [31:0] result,
                          input logic [31:0] rt, input logic [4:0] rd);
        mem_regwr       = regwr;
        mem_memtoreg    = memtoreg;
        mem_memwr       = memwr;
        mem_dmen        = dmen;
        mem_result      = result;
        mem_rt          = rt;
        mem_regdst_addr = rd;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset      = 1'b1;
        dbus.ack   = 1'b0;
        dbus.rdata = '0;
        set_op(0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        check("rst_stall", mem_stall, 0);
        check("rst_req", dbus.req, 0);
        check("rst_wb_regwr", wb_regwr, 0);
        check("rst_wb_result", wb_result, 0);
        check("rst_bus_err", bus_err, 0);

        // ALU op passes straight through
        s0 = stall_cnt;
        set_op(1, 0, 0, 0, 32'h1234, 0, 5);
        #1 check("alu_stall", mem_stall, 0);
        next_cycle();
        set_op(0, 0, 0, 0, 0, 0, 0);
        #1;
        check("alu_wb_result", wb_result, 32'h1234);
        check("alu_wb_regwr", wb_regwr, 1);
        check("alu_wb_rd", wb_regdst_addr, 5);
        check("alu_stall_cycles", stall_cnt - s0, 0);

        // Load, ack in first BUSY cycle
        s0 = stall_cnt; b0 = req_bursts;
        set_op(1, 1, 0, 1, 32'h100, 0, 7);
        #1 check("ld_idle_stall", mem_stall, 1);
        next_cycle();
        dbus.ack = 1'b1; dbus.rdata = 32'hCAFEF00D;
        #1;
        check("ld_busy_req", dbus.req, 1);
        check("ld_busy_addr", dbus.addr, 32'h100);
        check("ld_busy_we", dbus.we, 0);
        check("ld_busy_bubble", wb_regwr, 0);
        next_cycle();
        dbus.ack = 1'b0; dbus.rdata = '0;
        #1;
        check("ld_done_stall", mem_stall, 0);
        check("ld_done_req", dbus.req, 0);
        check("ld_done_addr", dbus.addr, 0);
        next_cycle();
        set_op(0, 0, 0, 0, 0, 0, 0);
        #1;
        check("ld_wb_rdata", wb_rdata, 32'hCAFEF00D);
        check("ld_wb_memtoreg", wb_memtoreg, 1);
        check("ld_wb_regwr", wb_regwr, 1);
        check("ld_wb_rd", wb_regdst_addr, 7);
        check("ld_stall_cycles", stall_cnt - s0, 2);
        check("ld_bursts", req_bursts - b0, 1);

        // Store, ack after 3 wait cycles -> 4 BUSY cycles
        s0 = stall_cnt;
        set_op(0, 0, 1, 1, 32'h200, 32'hA5A5A5A5, 0);
        #1;
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            if (i == 3) dbus.ack = 1'b1;
            #1;
            check("st_req", dbus.req, 1);
            check("st_we", dbus.we, 1);
            check("st_addr", dbus.addr, 32'h200);
            check("st_wdata", dbus.wdata, 32'hA5A5A5A5);
            check("st_stall", mem_stall, 1);
            check("st_bubble", wb_regwr, 0);
            check("st_wb_rd_hold", wb_regdst_addr, 7);
            check("st_bus_err", bus_err, 0);
        end
        next_cycle();
        dbus.ack = 1'b0;
        #1;
        check("st_done_we", dbus.we, 0);
        check("st_done_wdata", dbus.wdata, 0);
        check("st_done_req", dbus.req, 0);
        next_cycle();
        set_op(0, 0, 0, 0, 0, 0, 0);
        #1;
        check("st_wb_result", wb_result, 32'h200);
        check("st_stall_cycles", stall_cnt - s0, 5);

        // Back-to-back loads
        b0 = req_bursts;
        set_op(1, 1, 0, 1, 32'h10, 0, 8);
        next_cycle();
        dbus.ack = 1'b1; dbus.rdata = 32'h11111111;
        #1 check("b2b_a_addr", dbus.addr, 32'h10);
        next_cycle();
        dbus.ack = 1'b0; dbus.rdata = '0;
        #1 check("b2b_a_done_req", dbus.req, 0);
        next_cycle();
        set_op(1, 1, 0, 1, 32'h14, 0, 9);
        #1;
        check("b2b_a_wb_rdata", wb_rdata, 32'h11111111);
        check("b2b_a_wb_rd", wb_regdst_addr, 8);
        check("b2b_gap_req", dbus.req, 0);
        check("b2b_b_stall", mem_stall, 1);
        next_cycle();
        check("b2b_b_addr", dbus.addr, 32'h14);
        check("b2b_b_req", dbus.req, 1);
        next_cycle();
        dbus.ack = 1'b1; dbus.rdata = 32'h22222222;
        #1 check("b2b_b_addr_wait", dbus.addr, 32'h14);
        next_cycle();
        dbus.ack = 1'b0; dbus.rdata = '0;
        next_cycle();
        set_op(0, 0, 0, 0, 0, 0, 0);
        #1;
        check("b2b_b_wb_rdata", wb_rdata, 32'h22222222);
        check("b2b_b_wb_rd", wb_regdst_addr, 9);
        check("b2b_bursts", req_bursts - b0, 2);

        // Reset during BUSY
        set_op(1, 1, 0, 1, 32'h300, 0, 3);
        next_cycle();
        reset = 1'b1;
        #1 check("rb_busy_req", dbus.req, 1);
        next_cycle();
        reset = 1'b0;
        set_op(0, 0, 0, 0, 0, 0, 0);
        #1;
        check("rb_req", dbus.req, 0);
        check("rb_stall", mem_stall, 0);
        check("rb_wb_regwr", wb_regwr, 0);
        check("rb_wb_memtoreg", wb_memtoreg, 0);
        check("rb_wb_result", wb_result, 0);
        check("rb_wb_rdata", wb_rdata, 0);
        check("rb_wb_rd", wb_regdst_addr, 0);

        // Recovery after reset
        set_op(1, 0, 0, 0, 32'hBEEF, 0, 31);
        next_cycle();
        set_op(0, 0, 0, 0, 0, 0, 0);
        #1;
        check("rec_wb_result", wb_result, 32'hBEEF);
        check("rec_wb_rd", wb_regdst_addr, 31);
        check("rec_bus_err", bus_err, 0);

`ifdef MEM_TIMEOUT_EN
        // Timeout: ack never arrives, 8 BUSY cycles then abort
        set_op(1, 1, 0, 1, 32'h400, 0, 4);
        #1;
        for (int i = 0; i < 8; i++) begin
            next_cycle();
            #1;
            check("to_req", dbus.req, 1);
            check("to_stall", mem_stall, 1);
            check("to_no_err", bus_err, 0);
        end
        next_cycle();
        #1;
        check("to_done_req", dbus.req, 0);
        check("to_done_err", bus_err, 1);
        check("to_done_stall", mem_stall, 0);
        next_cycle();
        set_op(1, 0, 0, 0, 32'h55, 0, 2);
        #1;
        check("to_wb_regwr", wb_regwr, 0);
        check("to_wb_rdata", wb_rdata, 0);
        check("to_err_pulse_end", bus_err, 0);
        next_cycle();
        set_op(0, 0, 0, 0, 0, 0, 0);
        #1;
        check("to_resume_regwr", wb_regwr, 1);
        check("to_resume_result", wb_result, 32'h55);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
